bottleneck_seq: RTL and testbench

- Sequential width adapter between a 64-bit master port and a narrow 8- or 16-bit slave port, handshaked in the usual cyc/stb/ack style.
- Splits 1/2/4/8-byte master transfers into little-endian slave beats.
- Assembles read data, then zero- or sign-extends it to 64 bits.
- Sits between the CPU data port and the narrow peripheral/memory bus. Unlike the pass-through byte-only adapter, it handles multi-byte sizes and misalignment.

---
 rtl/bottleneck_seq.sv | 236 +++++++++++++++++++++++
 tb/tb_bottleneck_seq.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bottleneck_seq.sv
// bottleneck_seq: sequential width adapter between a 64-bit master port and a
// narrow 8- or 16-bit slave port (cyc/stb/ack handshake).
//
// A master transfer of 1, 2, 4 or 8 bytes is split into little-endian slave
// beats. A beat is a halfword when the slave is 16 bits wide, the transfer is
// at least 2 bytes and the start address is even; otherwise every beat is a
// single byte. Read beats are assembled into a 64-bit word, which is then
// zero- or sign-extended from the transfer size. All outputs are registered.
//
// Ports:
//   clk_i       clock, rising edge
//   reset_ni    asynchronous active-low reset
//   m_adr_i     master byte address
//   m_cyc_i     master cycle valid (dropping it during a transfer aborts it)
//   m_stb_i     master strobe
//   m_we_i      master write enable
//   m_siz_i     transfer size: 0=1B, 1=2B, 2=4B, 3=8B
//   m_signed_i  sign-extend the read result
//   m_dat_i     right-justified write data
//   m_ack_o     one-cycle completion pulse
//   m_dat_o     extended read data (held between transfers)
//   s_adr_o     slave beat address
//   s_cyc_o     slave cycle
//   s_stb_o     slave strobe
//   s_we_o      slave write enable
//   s_siz_o     0=byte beat, 1=halfword beat
//   s_dat_o     slave beat write data
//   s_ack_i     slave beat acknowledge
//   s_dat_i     slave beat read data

module bottleneck_seq #(
   parameter int SLAVE_BYTES = 2,
   parameter int ADR_W       = 64
) (
   input  logic                       clk_i,
   input  logic                       reset_ni,
   input  logic [ADR_W-1:0]           m_adr_i,
   input  logic                       m_cyc_i,
   input  logic                       m_stb_i,
   input  logic                       m_we_i,
   input  logic [1:0]                 m_siz_i,
   input  logic                       m_signed_i,
   input  logic [63:0]                m_dat_i,
   output logic                       m_ack_o,
   output logic [63:0]                m_dat_o,
   output logic [ADR_W-1:0]           s_adr_o,
   output logic                       s_cyc_o,
   output logic                       s_stb_o,
   output logic                       s_we_o,
   output logic                       s_siz_o,
   output logic [8*SLAVE_BYTES-1:0]   s_dat_o,
   input  logic                       s_ack_i,
   input  logic [8*SLAVE_BYTES-1:0]   s_dat_i
);

   localparam int SDW = 8 * SLAVE_BYTES;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUS  = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t      state_q;

   // Latched transfer attributes
   logic        we_q;
   logic        signed_q;
   logic [1:0]  siz_q;
   logic        bb2_q;      // beats are halfwords
   logic [2:0]  last_q;     // index of the final beat (N-1)
   logic [2:0]  k_q;        // current beat index
   logic [63:0] wshift_q;   // write data, current beat's lanes at the bottom
   logic [63:0] asm_q;      // read assembly register

   // ------------------------------------------------------------------
   // Request decode (used only on the accepting edge in IDLE)
   // ------------------------------------------------------------------
   logic       req_bb2;
   logic [2:0] req_last;

   assign req_bb2 = (SLAVE_BYTES == 2) && (m_siz_i != 2'd0) && !m_adr_i[0];

   always_comb begin
      // NOTE: every always_comb output gets a default before any branch so
      // that no path leaves it unassigned, which would infer a latch.
      req_last = 3'd0;
      unique case (m_siz_i)
         2'd0: req_last = 3'd0;
         2'd1: req_last = req_bb2 ? 3'd0 : 3'd1;
         2'd2: req_last = req_bb2 ? 3'd1 : 3'd3;
         2'd3: req_last = req_bb2 ? 3'd3 : 3'd7;
         default: req_last = 3'd0;
      endcase
   end

   // Lanes driven on the slave data bus for one beat. A byte beat on a
   // 16-bit slave keeps the upper lane at zero.
   function automatic logic [SDW-1:0] beat_lanes(input logic [15:0] d,
                                                 input logic        bb2);
      logic [15:0] w;
      w = bb2 ? d : {8'h00, d[7:0]};
      return w[SDW-1:0];
   endfunction

   // ------------------------------------------------------------------
   // Beat datapath
   // ------------------------------------------------------------------
   logic [63:0]      wshift_nxt;
   logic [15:0]      s_dat_pad;
   logic [15:0]      beat_rd;
   logic [3:0]       byte_off;
   logic [63:0]      asm_next;
   logic [ADR_W-1:0] adr_step;

   assign wshift_nxt = bb2_q ? {16'h0000, wshift_q[63:16]}
                             : {8'h00,    wshift_q[63:8]};

   // Only the low byte of the slave bus is meaningful on a byte beat.
   assign s_dat_pad = 16'(s_dat_i);
   assign beat_rd   = bb2_q ? s_dat_pad : {8'h00, s_dat_pad[7:0]};

   // Byte position of the current beat inside the assembled word.
   assign byte_off  = bb2_q ? {k_q, 1'b0} : {1'b0, k_q};
   assign asm_next  = asm_q | ({48'h0, beat_rd} << {byte_off, 3'b000});

   assign adr_step  = {{(ADR_W-2){1'b0}}, bb2_q, ~bb2_q};

   // Extension of the assembled word from the transfer size. Bytes above
   // the size are still zero in asm_next because the register is cleared
   // at the start of every transfer.
   logic [63:0] rd_ext;

   always_comb begin
      rd_ext = asm_next;
      unique case (siz_q)
         2'd0: rd_ext = {{56{signed_q & asm_next[7]}},  asm_next[7:0]};
         2'd1: rd_ext = {{48{signed_q & asm_next[15]}}, asm_next[15:0]};
         2'd2: rd_ext = {{32{signed_q & asm_next[31]}}, asm_next[31:0]};
         2'd3: rd_ext = asm_next;
         default: rd_ext = asm_next;
      endcase
   end

   // ------------------------------------------------------------------
   // Control FSM with registered outputs
   // ------------------------------------------------------------------
   // NOTE: state is updated with non-blocking assignments so that every
   // flop samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         state_q  <= IDLE;
         we_q     <= 1'b0;
         signed_q <= 1'b0;
         siz_q    <= 2'd0;
         bb2_q    <= 1'b0;
         last_q   <= 3'd0;
         k_q      <= 3'd0;
         wshift_q <= 64'h0;
         asm_q    <= 64'h0;
         m_ack_o  <= 1'b0;
         m_dat_o  <= 64'h0;
         s_adr_o  <= '0;
         s_cyc_o  <= 1'b0;
         s_stb_o  <= 1'b0;
         s_we_o   <= 1'b0;
         s_siz_o  <= 1'b0;
         s_dat_o  <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               m_ack_o <= 1'b0;
               if (m_cyc_i && m_stb_i) begin
                  we_q     <= m_we_i;
                  signed_q <= m_signed_i;
                  siz_q    <= m_siz_i;
                  bb2_q    <= req_bb2;
                  last_q   <= req_last;
                  k_q      <= 3'd0;
                  wshift_q <= m_dat_i;
                  asm_q    <= 64'h0;
                  s_cyc_o  <= 1'b1;
                  s_stb_o  <= 1'b1;
                  s_we_o   <= m_we_i;
                  s_siz_o  <= req_bb2;
                  s_adr_o  <= m_adr_i;
                  s_dat_o  <= beat_lanes(m_dat_i[15:0], req_bb2);
                  state_q  <= BUS;
               end
            end

            BUS: begin
               if (!m_cyc_i) begin
                  // Abort: a slave ack arriving in the same cycle is dropped.
                  s_cyc_o <= 1'b0;
                  s_stb_o <= 1'b0;
                  s_we_o  <= 1'b0;
                  state_q <= IDLE;
               end else if (s_ack_i) begin
                  if (!we_q) begin
                     asm_q <= asm_next;
                  end
                  if (k_q == last_q) begin
                     s_cyc_o <= 1'b0;
                     s_stb_o <= 1'b0;
                     s_we_o  <= 1'b0;
                     m_ack_o <= 1'b1;
                     if (!we_q) begin
                        m_dat_o <= rd_ext;
                     end
                     state_q <= ACK;
                  end else begin
                     k_q      <= k_q + 3'd1;
                     s_adr_o  <= s_adr_o + adr_step;
                     wshift_q <= wshift_nxt;
                     s_dat_o  <= beat_lanes(wshift_nxt[15:0], bb2_q);
                  end
               end
            end

            ACK: begin
               m_ack_o <= 1'b0;
               state_q <= IDLE;
            end

            default: begin
               m_ack_o <= 1'b0;
               s_cyc_o <= 1'b0;
               s_stb_o <= 1'b0;
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bottleneck_seq.sv
// Self-checking bench for bottleneck_seq (SLAVE_BYTES=2, ADR_W=64).
// A byte-addressed slave memory answers beats; expected beat addresses, beat
// data, read results and latency are derived from the transfer parameters
// with plain arithmetic over that memory.

module tb_bottleneck_seq;

   logic        clk_i = 1'b0;
   logic        reset_ni;
   logic [63:0] m_adr_i;
   logic        m_cyc_i;
   logic        m_stb_i;
   logic        m_we_i;
   logic [1:0]  m_siz_i;
   logic        m_signed_i;
   logic [63:0] m_dat_i;
   logic        m_ack_o;
   logic [63:0] m_dat_o;
   logic [63:0] s_adr_o;
   logic        s_cyc_o;
   logic        s_stb_o;
   logic        s_we_o;
   logic        s_siz_o;
   logic [15:0] s_dat_o;
   logic        s_ack_i;
   logic [15:0] s_dat_i;

   bottleneck_seq #(.SLAVE_BYTES(2), .ADR_W(64)) dut (
      .clk_i      (clk_i),
      .reset_ni   (reset_ni),
      .m_adr_i    (m_adr_i),
      .m_cyc_i    (m_cyc_i),
      .m_stb_i    (m_stb_i),
      .m_we_i     (m_we_i),
      .m_siz_i    (m_siz_i),
      .m_signed_i (m_signed_i),
      .m_dat_i    (m_dat_i),
      .m_ack_o    (m_ack_o),
      .m_dat_o    (m_dat_o),
      .s_adr_o    (s_adr_o),
      .s_cyc_o    (s_cyc_o),
      .s_stb_o    (s_stb_o),
      .s_we_o     (s_we_o),
      .s_siz_o    (s_siz_o),
      .s_dat_o    (s_dat_o),
      .s_ack_i    (s_ack_i),
      .s_dat_i    (s_dat_i)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;

   logic [63:0] exp_mdat;          // value m_dat_o must hold
   logic [7:0]  mem [logic [63:0]]; // slave memory

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h", tag, got, exp);
      end
   endtask

   // Unwritten locations return an address-derived pattern.
   function automatic logic [7:0] rd_byte(input logic [63:0] a);
      if (mem.exists(a)) return mem[a];
      return a[7:0] ^ a[15:8] ^ a[63:56] ^ 8'h5A;
   endfunction

   // Reference read: little-endian bytes from memory, then extension.
   function automatic logic [63:0] ref_read(input logic [63:0] adr,
                                            input logic [1:0] siz,
                                            input logic sgn);
      logic [63:0] v;
      logic        fill;
      int          sz;
      sz = 1 << siz;
      v  = 64'h0;
      for (int i = 0; i < sz; i++) v[8*i +: 8] = rd_byte(adr + 64'(i));
      fill = sgn & v[8*sz-1];
      for (int i = sz; i < 8; i++) v[8*i +: 8] = {8{fill}};
      return v;
   endfunction

   // One master transfer with the slave answering from mem.
   //   rnd_w      : random 0..2 wait cycles per beat
   //   wbeat, wn  : otherwise wn wait cycles before beat wbeat only
   //   abort_at   : >0 drops m_cyc_i once that many beats were acked
   task automatic xfer(input logic [63:0] adr, input logic [1:0] siz,
                       input logic we, input logic sgn, input logic [63:0] dat,
                       input bit rnd_w, input int wbeat, input int wn,
                       input int abort_at);
      int          sz, bb, nb, j, wl, wtot, edges;
      bit          got;
      logic [63:0] ea, exp_rd;
      logic [15:0] ed;
      sz     = 1 << siz;
      bb     = (siz != 2'd0 && !adr[0]) ? 2 : 1;
      nb     = sz / bb;
      exp_rd = ref_read(adr, siz, sgn);
      j = 0; wtot = 0; edges = 0; got = 1'b0;
      wl = rnd_w ? int'($urandom_range(0, 2)) : ((wbeat == 0) ? wn : 0);

      @(negedge clk_i);
      m_adr_i = adr; m_siz_i = siz; m_we_i = we; m_signed_i = sgn;
      m_dat_i = dat; m_cyc_i = 1'b1; m_stb_i = 1'b1;

      while (!got && edges < 200) begin
         @(negedge clk_i);
         edges++;
         s_ack_i = 1'b0;
         if (m_ack_o) begin
            got = 1'b1;
         end else if (s_stb_o) begin
            if (j < nb) begin
               ea = adr + 64'(j * bb);
               ed = (bb == 2) ? dat[16*j +: 16] : {8'h00, dat[8*j +: 8]};
               check("s_adr", s_adr_o, ea);
               check("s_siz", 64'(s_siz_o), 64'(bb == 2));
               check("s_we",  64'(s_we_o), 64'(we));
               check("s_cyc", 64'(s_cyc_o), 64'd1);
               if (we) check("s_dat", 64'(s_dat_o), 64'(ed));
            end else begin
               check("extra_beat", 64'(j), 64'(nb - 1));
            end

            if (abort_at > 0 && j == abort_at) begin
               // Drop the cycle while the slave acks: the ack must be ignored.
               m_cyc_i = 1'b0; m_stb_i = 1'b0;
               s_ack_i = 1'b1;
               s_dat_i = 16'hA5A5;
               @(negedge clk_i);
               s_ack_i = 1'b0;
               check("abort_cyc", 64'(s_cyc_o), 64'd0);
               check("abort_stb", 64'(s_stb_o), 64'd0);
               check("abort_ack", 64'(m_ack_o), 64'd0);
               repeat (3) begin
                  @(negedge clk_i);
                  check("abort_no_ack", 64'(m_ack_o), 64'd0);
               end
               check("abort_mdat", m_dat_o, exp_mdat);
               return;
            end

            if (wl > 0) begin
               wl--;
               wtot++;
            end else begin
               s_ack_i = 1'b1;
               if (s_siz_o)
                  s_dat_i = {rd_byte(s_adr_o + 64'd1), rd_byte(s_adr_o)};
               else
                  s_dat_i = {8'($urandom), rd_byte(s_adr_o)};
               if (s_we_o) begin
                  mem[s_adr_o] = s_dat_o[7:0];
                  if (s_siz_o) mem[s_adr_o + 64'd1] = s_dat_o[15:8];
               end
               j++;
               wl = rnd_w ? int'($urandom_range(0, 2)) : ((j == wbeat) ? wn : 0);
            end
         end
      end

      s_ack_i = 1'b0;
      check("ack_seen", 64'(got), 64'd1);
      if (got) begin
         // m_ack_o is visible after edge N+1+waits; the master samples it on
         // the following edge.
         check("latency", 64'(edges), 64'(nb + 1 + wtot));
         check("beats", 64'(j), 64'(nb));
         if (!we) exp_mdat = exp_rd;
         check("m_dat", m_dat_o, exp_mdat);
      end
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
      @(negedge clk_i);
      check("ack_pulse", 64'(m_ack_o), 64'd0);
      check("s_cyc_idle", 64'(s_cyc_o), 64'd0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [63:0] radr;
      logic [1:0]  rsiz;
      int          ab;

      reset_ni = 1'b0;
      m_adr_i = 64'h0; m_cyc_i = 1'b0; m_stb_i = 1'b0; m_we_i = 1'b0;
      m_siz_i = 2'd0; m_signed_i = 1'b0; m_dat_i = 64'h0;
      s_ack_i = 1'b0; s_dat_i = 16'h0;
      exp_mdat = 64'h0;

      repeat (2) @(negedge clk_i);
      check("rst_m_ack", 64'(m_ack_o), 64'd0);
      check("rst_s_cyc", 64'(s_cyc_o), 64'd0);
      check("rst_s_stb", 64'(s_stb_o), 64'd0);
      check("rst_s_we",  64'(s_we_o), 64'd0);
      check("rst_s_siz", 64'(s_siz_o), 64'd0);
      check("rst_s_adr", s_adr_o, 64'h0);
      check("rst_s_dat", 64'(s_dat_o), 64'h0);
      check("rst_m_dat", m_dat_o, 64'h0);
      reset_ni = 1'b1;
      @(negedge clk_i);

      // Aligned 64-bit read, four halfword beats.
      mem[64'h100] = 8'h22; mem[64'h101] = 8'h11;
      mem[64'h102] = 8'h44; mem[64'h103] = 8'h33;
      mem[64'h104] = 8'h66; mem[64'h105] = 8'h55;
      mem[64'h106] = 8'h77; mem[64'h107] = 8'h88;
      xfer(64'h100, 2'd3, 1'b0, 1'b0, 64'h0, 1'b0, 0, 0, 0);
      check("tp_read64", m_dat_o, 64'h8877_5566_3344_1122);

      // Signed / unsigned byte read of 0x80.
      mem[64'h7] = 8'h80;
      xfer(64'h7, 2'd0, 1'b0, 1'b1, 64'h0, 1'b0, 0, 0, 0);
      check("tp_sbyte", m_dat_o, 64'hFFFF_FFFF_FFFF_FF80);
      xfer(64'h7, 2'd0, 1'b0, 1'b0, 64'h0, 1'b0, 0, 0, 0);
      check("tp_ubyte", m_dat_o, 64'h0000_0000_0000_0080);

      // Misaligned 32-bit write: byte beats, m_dat_o unchanged.
      xfer(64'h201, 2'd2, 1'b1, 1'b0, 64'hDEAD_BEEF, 1'b0, 0, 0, 0);
      check("tp_wr_mdat", m_dat_o, 64'h0000_0000_0000_0080);
      check("tp_wr_mem", 64'({rd_byte(64'h204), rd_byte(64'h203),
                              rd_byte(64'h202), rd_byte(64'h201)}),
            64'hDEAD_BEEF);

      // Signed 32-bit read with three wait cycles on the second beat.
      mem[64'h10] = 8'h01; mem[64'h11] = 8'h00;
      mem[64'h12] = 8'h00; mem[64'h13] = 8'h80;
      xfer(64'h10, 2'd2, 1'b0, 1'b1, 64'h0, 1'b0, 1, 3, 0);
      check("tp_sword", m_dat_o, 64'hFFFF_FFFF_8000_0001);

      // Abort a 64-bit read after two beats, then a normal transfer.
      xfer(64'h400, 2'd3, 1'b0, 1'b0, 64'h0, 1'b0, 0, 0, 2);
      xfer(64'h100, 2'd3, 1'b0, 1'b0, 64'h0, 1'b0, 0, 0, 0);

      // Address wrap across 2^64.
      xfer(64'hFFFF_FFFF_FFFF_FFFE, 2'd3, 1'b0, 1'b1, 64'h0, 1'b0, 0, 0, 0);
      xfer(64'hFFFF_FFFF_FFFF_FFFF, 2'd1, 1'b1, 1'b0, 64'h1234, 1'b0, 0, 0, 0);

      // Asynchronous reset in the middle of a transfer.
      @(negedge clk_i);
      m_adr_i = 64'h300; m_siz_i = 2'd3; m_we_i = 1'b0; m_signed_i = 1'b0;
      m_cyc_i = 1'b1; m_stb_i = 1'b1;
      repeat (2) begin
         @(negedge clk_i);
         s_ack_i = 1'b1; s_dat_i = 16'h1357;
      end
      @(negedge clk_i);
      s_ack_i = 1'b0;
      #2 reset_ni = 1'b0;
      #1;
      check("mid_rst_s_cyc", 64'(s_cyc_o), 64'd0);
      check("mid_rst_s_stb", 64'(s_stb_o), 64'd0);
      check("mid_rst_m_ack", 64'(m_ack_o), 64'd0);
      check("mid_rst_m_dat", m_dat_o, 64'h0);
      exp_mdat = 64'h0;
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
      @(negedge clk_i);
      reset_ni = 1'b1;
      repeat (2) begin
         @(negedge clk_i);
         check("post_rst_ack", 64'(m_ack_o), 64'd0);
         check("post_rst_cyc", 64'(s_cyc_o), 64'd0);
      end

      // Randomized transfers.
      for (int t = 0; t < 80; t++) begin
         radr = {$urandom, $urandom};
         if ($urandom_range(0, 4) == 0)
            radr = 64'hFFFF_FFFF_FFFF_FFF8 | 64'($urandom_range(0, 7));
         else if ($urandom_range(0, 1) == 0)
            radr = 64'h1000 + 64'($urandom_range(0, 63));
         rsiz = 2'($urandom_range(0, 3));
         ab   = (rsiz == 2'd3 && $urandom_range(0, 9) == 0)
                ? int'($urandom_range(1, 3)) : 0;
         xfer(radr, rsiz, 1'($urandom), 1'($urandom),
              {$urandom, $urandom}, 1'b1, 0, 0, ab);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
